keynsham_mem_arbiter: RTL and testbench
=======================================

# keynsham_mem_arbiter

Three-requester arbiter that shares the single keynsham SoC memory slave port (SDRAM controller / on-chip RAM decode) between the debug controller bridge, the CPU data port and the CPU instruction-fetch port. It registers a grant, forwards the winning requester's transaction to the slave port, and routes the slave acknowledge and read data back. Debug has absolute priority; data and instruction fetch share the remainder round-robin.

## Interface
- TIMEOUT_CYCLES, 1023: slave-ack watchdog limit in clk cycles (used only with KEYNSHAM_ARB_TIMEOUT_EN); minimum 2.
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  reset; asynchronous, active-high
- Per requester X in {dbg, d, i}:
  - X_access  in  1  request, held high until X_ack
  - X_addr  in  30  word address [31:2]
  - X_wr_en  in  1  1 = write
  - X_wr_val  in  32  write data
  - X_bytesel  in  4  byte enables
  - X_ack  out  1  one-cycle completion strobe
  - X_data  out  32  read data, valid when X_ack
- s_access  out  1  slave request
- s_addr  out  30  slave word address
- s_wr_en  out  1  slave write enable
- s_wr_val  out  32  slave write data
- s_bytesel  out  4  slave byte enables
- s_ack  in  1  slave completion strobe
- s_data  in  32  slave read data
- bus_error  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, BUSY. Registered grant: NONE, DBG, D, I. Registered last_di (D or I), reset to I.
- IDLE: sample requests; if any asserted, load grant and go BUSY next edge. Priority: dbg_access wins; else if both d_access and i_access, grant the one not equal to last_di; else the sole requester. No request: stay IDLE, grant NONE.
- On granting D or I, update last_di to that requester. Debug grants do not touch last_di.
- BUSY: s_access = 1; s_addr/s_wr_en/s_wr_val/s_bytesel muxed combinationally from the granted requester's inputs. Inputs must remain stable while access is high (requester contract, not checked).
- X_ack = s_ack AND (grant == X) AND BUSY, combinational. X_data = s_data to all requesters (unqualified broadcast).
- s_ack in BUSY: next state IDLE, grant NONE. The mandatory IDLE cycle lets the acked requester drop access before re-arbitration.
- s_ack while IDLE: ignored, no X_ack produced.
- Requester dropping access mid-BUSY: ignored; transaction runs to s_ack.

## Timing
- Reset values: s_access 0, all X_ack 0, bus_error 0, s_* mux outputs 0 (grant NONE selects zeros), state IDLE, last_di = I.
- Grant latency: request seen at edge N in IDLE -> s_access high from edge N+1.
- Ack path: zero cycles, s_ack to X_ack combinational.
- Back-to-back throughput: one transaction per (slave latency + 2) cycles; a slave acking in the first BUSY cycle gives 2 cycles/access.
- Async rst mid-BUSY: outputs return to reset values immediately; in-flight slave access abandoned.

## Configuration
- KEYNSHAM_ARB_TIMEOUT_EN defined: 32-bit counter cleared on entry to BUSY, incremented each BUSY cycle without s_ack. When it reaches TIMEOUT_CYCLES-1 without s_ack: X_ack pulses for the granted requester, X_data forced to 32'hdeadbeef that cycle, bus_error pulses, state -> IDLE. s_ack arriving on the same cycle takes precedence (normal ack, no error).
- Undefined: no counter, BUSY waits indefinitely for s_ack, bus_error tied 0.

## Test plan
- Single D read: d_access with d_addr 30'h100, slave acks 3 cycles after s_access with 32'h12345678 -> s_access one cycle after request, s_addr 30'h100, d_ack one cycle with d_data 32'h12345678, i_ack/dbg_ack stay 0.
- D and I asserted same cycle out of reset -> D granted first (last_di = I), then I after IDLE cycle, then D again if both persist: alternating D,I,D,I.
- dbg_access asserted during a D BUSY and I pending -> D completes, then DBG granted, then I; last_di unaffected by DBG grant.
- Write passthrough: i idle, d write 32'hcafef00d bytesel 4'b0011 -> s_wr_en 1, s_wr_val 32'hcafef00d, s_bytesel 4'b0011 for the whole BUSY period.
- Async rst pulsed mid-BUSY -> s_access and all acks 0 within the same cycle, later requests arbitrate from reset state.
- With KEYNSHAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> after 8 BUSY cycles d_ack and bus_error pulse together, d_data 32'hdeadbeef, arbiter returns IDLE; without the macro, s_access stays high indefinitely.

Source files
------------

// File: rtl/keynsham_mem_arbiter.sv
// rtl/keynsham_mem_arbiter.sv - three-requester arbiter for the keynsham SoC memory slave port
//
// Shares one memory slave port between the debug bridge (dbg), the CPU data
// port (d) and the CPU instruction-fetch port (i). Debug always wins; d and i
// alternate round-robin when both are waiting. Every transaction is followed
// by one IDLE cycle so the acked requester can drop its request before the
// next arbitration.
//
// Optional feature macro: KEYNSHAM_ARB_TIMEOUT_EN
//   Defined   - slave-ack watchdog; after TIMEOUT_CYCLES BUSY cycles without
//               s_ack the granted requester is acked with 32'hdeadbeef and
//               bus_error pulses for one cycle.
//   Undefined - BUSY waits indefinitely for s_ack; bus_error tied low.
//
// Parameters:
//   TIMEOUT_CYCLES   watchdog limit in clk cycles (minimum 2)
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   <x>_access/_addr/_wr_en/_wr_val/_bytesel   requester x in {dbg, d, i}
//   <x>_ack, <x>_data                 completion strobe and read data to x
//   s_access/_addr/_wr_en/_wr_val/_bytesel     request to memory slave
//   s_ack, s_data                     completion strobe and read data from slave
//   bus_error                         one-cycle pulse on watchdog expiry

module keynsham_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        dbg_access,
    input  logic [29:0] dbg_addr,
    input  logic        dbg_wr_en,
    input  logic [31:0] dbg_wr_val,
    input  logic [3:0]  dbg_bytesel,
    output logic        dbg_ack,
    output logic [31:0] dbg_data,

    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic [3:0]  d_bytesel,
    output logic        d_ack,
    output logic [31:0] d_data,

    input  logic        i_access,
    input  logic [29:0] i_addr,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_val,
    input  logic [3:0]  i_bytesel,
    output logic        i_ack,
    output logic [31:0] i_data,

    output logic        s_access,
    output logic [29:0] s_addr,
    output logic        s_wr_en,
    output logic [31:0] s_wr_val,
    output logic [3:0]  s_bytesel,
    input  logic        s_ack,
    input  logic [31:0] s_data,

    output logic        bus_error
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DBG,
        GNT_D,
        GNT_I
    } grant_t;

    localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

    state_t state_q, state_d;
    grant_t grant_q, grant_d;
    // Only ever GNT_D or GNT_I: the last CPU port served, for round-robin.
    grant_t last_di_q, last_di_d;

    logic busy;
    logic timeout;

    assign busy = (state_q == ST_BUSY);

`ifdef KEYNSHAM_ARB_TIMEOUT_EN
    logic [31:0] wdog_cnt_q;

    // The count is held at zero whenever IDLE, so it starts from zero on
    // every entry to BUSY. s_ack on the expiry cycle wins over the watchdog.
    assign timeout = busy && !s_ack && (wdog_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= 32'd0;
        end else if (!busy) begin
            wdog_cnt_q <= 32'd0;
        end else if (!s_ack && !timeout) begin
            wdog_cnt_q <= wdog_cnt_q + 32'd1;
        end
    end

    assign bus_error = timeout;
`else
    // Watchdog compiled out; the limit is kept only so both builds share
    // one parameter list.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;

    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, grant and round-robin registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_NONE;
            last_di_q <= GNT_I;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_di_q <= last_di_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_di_d = last_di_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = GNT_NONE;
                if (dbg_access) begin
                    // Debug grants leave the d/i round-robin untouched.
                    grant_d = GNT_DBG;
                    state_d = ST_BUSY;
                end else if (d_access && i_access) begin
                    if (last_di_q == GNT_I) begin
                        grant_d   = GNT_D;
                        last_di_d = GNT_D;
                    end else begin
                        grant_d   = GNT_I;
                        last_di_d = GNT_I;
                    end
                    state_d = ST_BUSY;
                end else if (d_access) begin
                    grant_d   = GNT_D;
                    last_di_d = GNT_D;
                    state_d   = ST_BUSY;
                end else if (i_access) begin
                    grant_d   = GNT_I;
                    last_di_d = GNT_I;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Requesters dropping access mid-transaction are ignored;
                // only the slave (or the watchdog) ends a transaction.
                if (s_ack || timeout) begin
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slave-side request mux. GNT_NONE drives zeros, so the port is quiet
    // in IDLE and straight out of reset.
    // ------------------------------------------------------------------
    always_comb begin
        s_addr    = 30'd0;
        s_wr_en   = 1'b0;
        s_wr_val  = 32'd0;
        s_bytesel = 4'd0;

        case (grant_q)
            GNT_DBG: begin
                s_addr    = dbg_addr;
                s_wr_en   = dbg_wr_en;
                s_wr_val  = dbg_wr_val;
                s_bytesel = dbg_bytesel;
            end
            GNT_D: begin
                s_addr    = d_addr;
                s_wr_en   = d_wr_en;
                s_wr_val  = d_wr_val;
                s_bytesel = d_bytesel;
            end
            GNT_I: begin
                s_addr    = i_addr;
                s_wr_en   = i_wr_en;
                s_wr_val  = i_wr_val;
                s_bytesel = i_bytesel;
            end
            default: begin
                s_addr    = 30'd0;
                s_wr_en   = 1'b0;
                s_wr_val  = 32'd0;
                s_bytesel = 4'd0;
            end
        endcase
    end

    assign s_access = busy;

    // ------------------------------------------------------------------
    // Response path: zero-cycle ack routing, read data broadcast.
    // s_ack seen in IDLE produces no requester ack.
    // ------------------------------------------------------------------
    logic        done;
    logic [31:0] rd_data;

    assign done    = busy && (s_ack || timeout);
    assign rd_data = timeout ? ERR_DATA : s_data;

    assign dbg_ack = done && (grant_q == GNT_DBG);
    assign d_ack   = done && (grant_q == GNT_D);
    assign i_ack   = done && (grant_q == GNT_I);

    assign dbg_data = rd_data;
    assign d_data   = rd_data;
    assign i_data   = rd_data;

endmodule

// File: tb/tb_keynsham_mem_arbiter.sv
// tb/tb_keynsham_mem_arbiter.sv - directed self-checking bench for keynsham_mem_arbiter

module tb_keynsham_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        dbg_access, dbg_wr_en, d_access, d_wr_en, i_access, i_wr_en;
    logic [29:0] dbg_addr, d_addr, i_addr;
    logic [31:0] dbg_wr_val, d_wr_val, i_wr_val;
    logic [3:0]  dbg_bytesel, d_bytesel, i_bytesel;
    logic        dbg_ack, d_ack, i_ack;
    logic [31:0] dbg_data, d_data, i_data;

    logic        s_access, s_wr_en, s_ack;
    logic [29:0] s_addr;
    logic [31:0] s_wr_val, s_data;
    logic [3:0]  s_bytesel;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keynsham_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .dbg_access(dbg_access), .dbg_addr(dbg_addr), .dbg_wr_en(dbg_wr_en),
        .dbg_wr_val(dbg_wr_val), .dbg_bytesel(dbg_bytesel), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en),
        .d_wr_val(d_wr_val), .d_bytesel(d_bytesel), .d_ack(d_ack), .d_data(d_data),
        .i_access(i_access), .i_addr(i_addr), .i_wr_en(i_wr_en),
        .i_wr_val(i_wr_val), .i_bytesel(i_bytesel), .i_ack(i_ack), .i_data(i_data),
        .s_access(s_access), .s_addr(s_addr), .s_wr_en(s_wr_en), .s_wr_val(s_wr_val),
        .s_bytesel(s_bytesel), .s_ack(s_ack), .s_data(s_data),
        .bus_error(bus_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, dbg_ack, d_ack, i_ack};
    endfunction

    // Entered just after a negedge with the arbiter IDLE and requests applied.
    // Waits lat BUSY cycles, then acks with rdata; returns just after the
    // following negedge, in the mandatory IDLE cycle.
    task automatic serve(input string tag, input logic [29:0] addr, input logic [2:0] who,
                         input int lat, input logic [31:0] rdata);
        logic [31:0] got_data;
        @(negedge clk); #1;
        for (int k = 0; k < lat; k++) begin
            check({tag, " wait s_access"}, 32'(s_access), 32'd1);
            check({tag, " wait acks"}, acks(), 32'd0);
            @(negedge clk); #1;
        end
        check({tag, " s_access"}, 32'(s_access), 32'd1);
        check({tag, " s_addr"}, 32'(s_addr), 32'(addr));
        s_ack  = 1'b1;
        s_data = rdata;
        #1;
        check({tag, " acks"}, acks(), 32'(who));
        got_data = (who == 3'b100) ? dbg_data : (who == 3'b010) ? d_data : i_data;
        check({tag, " data"}, got_data, rdata);
        @(negedge clk);
        s_ack = 1'b0;
        #1;
        check({tag, " idle s_access"}, 32'(s_access), 32'd0);
        check({tag, " idle acks"}, acks(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        dbg_access = 0; dbg_addr = 0; dbg_wr_en = 0; dbg_wr_val = 0; dbg_bytesel = 0;
        d_access = 0;   d_addr = 0;   d_wr_en = 0;   d_wr_val = 0;   d_bytesel = 0;
        i_access = 0;   i_addr = 0;   i_wr_en = 0;   i_wr_val = 0;   i_bytesel = 0;
        s_ack = 0; s_data = 0;

        // Reset state
        #2;
        check("rst s_access", 32'(s_access), 32'd0);
        check("rst acks", acks(), 32'd0);
        check("rst bus_error", 32'(bus_error), 32'd0);
        check("rst s_addr", 32'(s_addr), 32'd0);
        check("rst s_wr_val", s_wr_val, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single D read, slave acks in the third BUSY cycle
        d_addr = 30'h100; d_access = 1'b1;
        serve("d_read", 30'h100, 3'b010, 2, 32'h12345678);
        d_access = 1'b0;

        // Round-robin from reset: D,I,D,I with both held
        rst = 1'b1; #1; rst = 1'b0;
        d_addr = 30'h200; i_addr = 30'h300;
        d_access = 1'b1; i_access = 1'b1;
        serve("rr1 d", 30'h200, 3'b010, 0, 32'h11111111);
        serve("rr2 i", 30'h300, 3'b001, 0, 32'h22222222);
        serve("rr3 d", 30'h200, 3'b010, 0, 32'h33333333);
        serve("rr4 i", 30'h300, 3'b001, 0, 32'h44444444);
        d_access = 1'b0; i_access = 1'b0;

        // Debug arrives during a D transaction with I pending
        d_access = 1'b1; dbg_addr = 30'h3ff00;
        @(negedge clk); #1;
        check("dbg_pre d s_addr", 32'(s_addr), 32'h200);
        dbg_access = 1'b1; i_access = 1'b1;
        @(negedge clk); #1;
        check("dbg_pre d still", 32'(s_addr), 32'h200);
        s_ack = 1'b1; s_data = 32'h55555555; #1;
        check("dbg_pre d ack", acks(), 32'b010);
        @(negedge clk); s_ack = 1'b0; #1;
        check("dbg_pre idle", 32'(s_access), 32'd0);
        serve("dbg grant", 30'h3ff00, 3'b100, 1, 32'h66666666);
        dbg_access = 1'b0;
        serve("post_dbg i", 30'h300, 3'b001, 0, 32'h77777777);
        serve("post_dbg d", 30'h200, 3'b010, 0, 32'h88888888);
        d_access = 1'b0; i_access = 1'b0;

        // Write passthrough for the whole BUSY period
        d_addr = 30'h40; d_wr_en = 1'b1; d_wr_val = 32'hcafef00d; d_bytesel = 4'b0011;
        d_access = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wr s_wr_en", 32'(s_wr_en), 32'd1);
            check("wr s_wr_val", s_wr_val, 32'hcafef00d);
            check("wr s_bytesel", 32'(s_bytesel), 32'h3);
            @(negedge clk);
        end
        #1;
        s_ack = 1'b1; #1;
        check("wr ack", acks(), 32'b010);
        check("wr s_wr_val last", s_wr_val, 32'hcafef00d);
        @(negedge clk); s_ack = 1'b0; d_access = 1'b0; d_wr_en = 1'b0; #1;
        check("wr idle s_wr_en", 32'(s_wr_en), 32'd0);
        check("wr idle s_bytesel", 32'(s_bytesel), 32'd0);

        // Async reset mid-BUSY (D granted so last_di = D beforehand)
        d_addr = 30'h200; d_access = 1'b1;
        @(negedge clk); #1;
        check("arst busy", 32'(s_access), 32'd1);
        s_ack = 1'b1; rst = 1'b1; #1;
        check("arst s_access", 32'(s_access), 32'd0);
        check("arst acks", acks(), 32'd0);
        check("arst s_addr", 32'(s_addr), 32'd0);
        s_ack = 1'b0; rst = 1'b0;
        i_access = 1'b1;
        serve("arst then d", 30'h200, 3'b010, 0, 32'h99999999);
        d_access = 1'b0; i_access = 1'b0;

        // s_ack while IDLE is ignored
        s_ack = 1'b1; s_data = 32'h0badf00d; #1;
        check("idle s_ack acks", acks(), 32'd0);
        @(negedge clk); s_ack = 1'b0; #1;
        check("idle s_ack s_access", 32'(s_access), 32'd0);

        // Slave never acks
        s_data = 32'd0;
        d_addr = 30'h55; d_access = 1'b1;
        @(negedge clk); #1;
        for (int k = 1; k < 8; k++) begin
            check("wdog wait s_access", 32'(s_access), 32'd1);
            check("wdog wait acks", acks(), 32'd0);
            check("wdog wait bus_error", 32'(bus_error), 32'd0);
            @(negedge clk); #1;
        end
`ifdef KEYNSHAM_ARB_TIMEOUT_EN
        check("wdog d_ack", acks(), 32'b010);
        check("wdog bus_error", 32'(bus_error), 32'd1);
        check("wdog d_data", d_data, 32'hdeadbeef);
        @(negedge clk); d_access = 1'b0; #1;
        check("wdog idle", 32'(s_access), 32'd0);
        check("wdog err cleared", 32'(bus_error), 32'd0);
`else
        for (int k = 0; k < 13; k++) begin
            check("nowdog s_access", 32'(s_access), 32'd1);
            check("nowdog bus_error", 32'(bus_error), 32'd0);
            check("nowdog acks", acks(), 32'd0);
            @(negedge clk); #1;
        end
        s_ack = 1'b1; #1;
        check("nowdog late ack", acks(), 32'b010);
        @(negedge clk); s_ack = 1'b0; d_access = 1'b0; #1;
        check("nowdog idle", 32'(s_access), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
